// File: rtl/core_dmaeng.sv
// core_dmaeng: bus-master DMA engine for block page copies and audio
// sample fetches; halts the CPU via O_ready and aligns reads to parity.
module core_dmaeng #(
  parameter logic [15:0] P_TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] P_DEST_ADDR    = 16'h2004,
  parameter int          P_LEN_WIDTH    = 8,
  parameter bit          P_ALIGN        = 1'b1,
  parameter bit          P_SMP_ENABLE   = 1'b1
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_phy2,
  input  logic [15:0] I_cpu_addr,
  input  logic [7:0]  I_cpu_wr_data,
  input  logic        I_cpu_rdwr,
  input  logic [7:0]  I_rd_data,
  output logic [15:0] O_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_rdwr,
  output logic        O_ready,
  input  logic        I_smp_req,
  input  logic [15:0] I_smp_addr,
  output logic [7:0]  O_smp_data,
  output logic        O_smp_ack,
  output logic        O_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_ALIGN, S_GET, S_PUT, S_SMP
  } state_t;

  state_t                 state_q, state_d;
  logic                   phy2_q;
  logic                   parity_q, parity_d;
  logic [7:0]             page_q, page_d;
  logic [P_LEN_WIDTH-1:0] off_q, off_d;
  logic [7:0]             data_q, data_d;
  logic                   pend_q, pend_d;
  logic [15:0]            saddr_q, saddr_d;
  logic                   blk_q, blk_d;
  logic [7:0]             sdata_q, sdata_d;
  logic                   ack_q, ack_d;

  logic   bnd;
  logic   req;
  logic   trig;
  logic   need_align;
  state_t resume;

  assign bnd  = phy2_q & ~I_phy2;
  assign req  = P_SMP_ENABLE && I_smp_req;
  assign trig = (I_cpu_addr == P_TRIGGER_ADDR) && !I_cpu_rdwr && !blk_q;

  // Next cycle runs at parity ~parity_q; reads must land on parity 0.
  assign need_align = P_ALIGN && !parity_q;
  assign resume     = need_align ? S_ALIGN : S_GET;

  always_comb begin
    state_d  = state_q;
    parity_d = parity_q;
    page_d   = page_q;
    off_d    = off_q;
    data_d   = data_q;
    pend_d   = pend_q;
    saddr_d  = saddr_q;
    blk_d    = blk_q;
    sdata_d  = sdata_q;
    ack_d    = 1'b0;
    if (bnd) begin
      parity_d = ~parity_q;
      if (req && !pend_q && state_q != S_SMP) begin
        pend_d  = 1'b1;
        saddr_d = I_smp_addr;
      end
      unique case (state_q)
        S_IDLE: begin
          if (trig) begin
            page_d  = I_cpu_wr_data;
            off_d   = '0;
            blk_d   = 1'b1;
            state_d = S_HALT;
          end
          if (req) state_d = S_HALT;
        end
        S_HALT: begin
          if (I_cpu_rdwr) begin
            if (need_align)  state_d = S_ALIGN;
            else if (pend_q) state_d = S_SMP;
            else             state_d = S_GET;
          end
        end
        S_ALIGN: state_d = pend_q ? S_SMP : S_GET;
        S_GET: begin
          data_d  = I_rd_data;
          state_d = S_PUT;
        end
        S_PUT: begin
          off_d = off_q + P_LEN_WIDTH'(1);
          if (&off_q) blk_d = 1'b0;
          if (pend_q)      state_d = S_SMP;
          else if (&off_q) state_d = S_IDLE;
          else             state_d = resume;
        end
        S_SMP: begin
          sdata_d = I_rd_data;
          ack_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = blk_q ? resume : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state_q  <= S_IDLE;
      phy2_q   <= 1'b0;
      parity_q <= 1'b0;
      page_q   <= '0;
      off_q    <= '0;
      data_q   <= '0;
      pend_q   <= 1'b0;
      saddr_q  <= '0;
      blk_q    <= 1'b0;
      sdata_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phy2_q   <= I_phy2;
      parity_q <= parity_d;
      page_q   <= page_d;
      off_q    <= off_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      saddr_q  <= saddr_d;
      blk_q    <= blk_d;
      sdata_q  <= sdata_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    O_addr    = I_cpu_addr;
    O_wr_data = I_cpu_wr_data;
    O_rdwr    = I_cpu_rdwr;
    case (state_q)
      S_GET: begin
        O_addr = {page_q, 8'(off_q)};
        O_rdwr = 1'b1;
      end
      S_PUT: begin
        O_addr    = P_DEST_ADDR;
        O_wr_data = data_q;
        O_rdwr    = 1'b0;
      end
      S_SMP: begin
        O_addr = saddr_q;
        O_rdwr = 1'b1;
      end
      default: ;
    endcase
  end

  assign O_ready    = (state_q == S_IDLE);
  assign O_busy     = (state_q != S_IDLE);
  assign O_smp_data = sdata_q;
  assign O_smp_ack  = ack_q;

endmodule

// File: tb/tb_core_dmaeng.sv
// tb_core_dmaeng: randomized bench for core_dmaeng with a memory model
// and expectations derived from copy length, parity and byte order.
module tb_core_dmaeng;

  logic        I_clock = 1'b0;
  logic        I_reset;
  logic        I_phy2;
  logic [15:0] I_cpu_addr;
  logic [7:0]  I_cpu_wr_data;
  logic        I_cpu_rdwr;
  logic        I_smp_req;
  logic [15:0] I_smp_addr;

  logic [15:0] a8, a4;
  logic [7:0]  w8, w4, sd8, sd4, rd8, rd4;
  logic        rw8, rw4, rdy8, rdy4, ack8, ack4, bsy8, bsy4;

  logic [7:0] mem [0:65535];
  assign rd8 = mem[a8];
  assign rd4 = mem[a4];

  core_dmaeng u8 (
    .I_clock(I_clock), .I_reset(I_reset), .I_phy2(I_phy2),
    .I_cpu_addr(I_cpu_addr), .I_cpu_wr_data(I_cpu_wr_data),
    .I_cpu_rdwr(I_cpu_rdwr), .I_rd_data(rd8),
    .O_addr(a8), .O_wr_data(w8), .O_rdwr(rw8), .O_ready(rdy8),
    .I_smp_req(I_smp_req), .I_smp_addr(I_smp_addr),
    .O_smp_data(sd8), .O_smp_ack(ack8), .O_busy(bsy8)
  );

  core_dmaeng #(.P_LEN_WIDTH(4)) u4 (
    .I_clock(I_clock), .I_reset(I_reset), .I_phy2(I_phy2),
    .I_cpu_addr(I_cpu_addr), .I_cpu_wr_data(I_cpu_wr_data),
    .I_cpu_rdwr(I_cpu_rdwr), .I_rd_data(rd4),
    .O_addr(a4), .O_wr_data(w4), .O_rdwr(rw4), .O_ready(rdy4),
    .I_smp_req(I_smp_req), .I_smp_addr(I_smp_addr),
    .O_smp_data(sd4), .O_smp_ack(ack4), .O_busy(bsy4)
  );

  always #5 I_clock = ~I_clock;

  bit sel;
  logic [15:0] o_addr;
  logic [7:0]  o_wdata, o_sdata;
  logic        o_rdwr, o_ready, o_ack, o_busy;
  assign o_addr  = sel ? a4 : a8;
  assign o_wdata = sel ? w4 : w8;
  assign o_rdwr  = sel ? rw4 : rw8;
  assign o_ready = sel ? rdy4 : rdy8;
  assign o_ack   = sel ? ack4 : ack8;
  assign o_busy  = sel ? bsy4 : bsy8;
  assign o_sdata = sel ? sd4 : sd8;

  int checks, errors, cyc, ack_cnt, odd_reads;
  logic [15:0] rd_q [$];
  logic [7:0]  wr_q [$];
  logic [15:0] exp_rd [$];
  logic [15:0] s_addr;
  logic [7:0]  s_wdata, smp_got;
  logic        s_ready, s_rdwr, s_busy;
  bit          arm_en;
  logic [15:0] arm_addr;

  initial begin
    ack_cnt = 0;
    forever begin
      @(negedge I_clock);
      if (o_ack) ack_cnt++;
    end
  end

  // One bus cycle: phy2 high for a clock, low for a clock, then boundary.
  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d,
                           input logic rw);
    I_cpu_addr = a;
    I_cpu_wr_data = d;
    I_cpu_rdwr = rw;
    I_phy2 = 1'b1;
    @(posedge I_clock); #1;
    I_phy2 = 1'b0;
    s_addr = o_addr;
    s_wdata = o_wdata;
    s_rdwr = o_rdwr;
    s_ready = o_ready;
    s_busy = o_busy;
    if (!s_ready && s_rdwr && s_addr != a) begin
      rd_q.push_back(s_addr);
      if (cyc % 2 != 0) odd_reads++;
    end
    if (!s_ready && !s_rdwr && s_addr == 16'h2004) wr_q.push_back(s_wdata);
    if (arm_en && !s_ready && s_rdwr && s_addr == arm_addr) begin
      I_smp_req = 1'b1;
      arm_en = 1'b0;
    end
    @(posedge I_clock); #1;
    cyc++;
    if (o_ack) begin
      smp_got = o_sdata;
      I_smp_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    I_reset = 1'b1;
    I_phy2 = 1'b0;
    I_smp_req = 1'b0;
    @(posedge I_clock); #1;
    I_reset = 1'b0;
    cyc = 0;
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wr_q.delete();
    exp_rd.delete();
    odd_reads = 0;
  endtask

  task automatic run_idle(output int low, output bit to);
    low = 0;
    to = 1'b1;
    for (int n = 0; n < 1200; n++) begin
      bus_cycle(16'hFFF0, 8'h00, 1'b1);
      if (s_ready) begin
        to = 1'b0;
        break;
      end
      low++;
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    I_cpu_addr = 16'($urandom);
    I_cpu_wr_data = 8'($urandom);
    I_cpu_rdwr = 1'b0;
    do_reset();
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_busy got %b%b exp 10", o_ready, o_busy);
    end
    checks++;
    if (o_sdata !== 8'h00 || o_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_smp got %h/%b exp 00/0", o_sdata, o_ack);
    end
    checks++;
    if (o_addr !== I_cpu_addr || o_wdata !== I_cpu_wr_data
        || o_rdwr !== I_cpu_rdwr) begin
      errors++;
      $display("FAIL reset_passthru got %h %h %b exp %h %h %b",
               o_addr, o_wdata, o_rdwr,
               I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr);
    end
  endtask

  task automatic test_full_copy(input int pad);
    logic [7:0] pg;
    int t, low, bad;
    bit to;
    sel = 1'b0;
    do_reset();
    pg = 8'h02;
    for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < pad; i++) bus_cycle(16'hFFF0, 8'h00, 1'b1);
    clear_logs();
    t = cyc;
    bus_cycle(16'h4014, pg, 1'b0);
    checks++;
    if (s_ready !== 1'b1 || s_addr !== 16'h4014 || s_rdwr !== 1'b0) begin
      errors++;
      $display("FAIL copy_trig_cycle got rdy=%b a=%h rw=%b exp 1 4014 0",
               s_ready, s_addr, s_rdwr);
    end
    run_idle(low, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL copy_timeout got busy exp idle");
    end
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i] !== (8'(i) ^ 8'hA5)) bad++;
    checks++;
    if (wr_q.size() != 256 || bad != 0) begin
      errors++;
      $display("FAIL copy_writes got n=%0d bad=%0d exp n=256 bad=0",
               wr_q.size(), bad);
    end
    bad = 0;
    foreach (rd_q[i]) if (rd_q[i] !== {pg, 8'(i)}) bad++;
    checks++;
    if (rd_q.size() != 256 || bad != 0 || odd_reads != 0) begin
      errors++;
      $display("FAIL copy_reads got n=%0d bad=%0d odd=%0d exp 256 0 0",
               rd_q.size(), bad, odd_reads);
    end
    checks++;
    if (low != 513 + (t % 2)) begin
      errors++;
      $display("FAIL copy_ready_low got %0d exp %0d", low, 513 + (t % 2));
    end
  endtask

  task automatic test_cpu_write();
    logic [7:0] pg, d;
    int t, k, low, bad;
    bit to;
    sel = 1'b0;
    do_reset();
    pg = 8'($urandom_range(3, 8'h7F));
    for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'($urandom);
    for (int i = 0; i < int'($urandom_range(0, 1)); i++)
      bus_cycle(16'hFFF0, 8'h00, 1'b1);
    clear_logs();
    t = cyc;
    bus_cycle(16'h4014, pg, 1'b0);
    k = $urandom_range(1, 3);
    for (int i = 0; i < k; i++) begin
      d = 8'($urandom);
      bus_cycle(16'h0010, d, 1'b0);
      checks++;
      if (s_ready !== 1'b0 || s_busy !== 1'b1 || s_addr !== 16'h0010
          || s_rdwr !== 1'b0 || s_wdata !== d) begin
        errors++;
        $display("FAIL halt_on_write got rdy=%b bsy=%b a=%h rw=%b d=%h exp 0 1 0010 0 %h",
                 s_ready, s_busy, s_addr, s_rdwr, s_wdata, d);
      end
    end
    run_idle(low, to);
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i] !== mem[{pg, 8'(i)}]) bad++;
    checks++;
    if (to || wr_q.size() != 256 || bad != 0) begin
      errors++;
      $display("FAIL wrhalt_copy got to=%0d n=%0d bad=%0d exp 0 256 0",
               to, wr_q.size(), bad);
    end
    checks++;
    if (low != 513 + ((t + k) % 2)) begin
      errors++;
      $display("FAIL wrhalt_ready_low got %0d exp %0d",
               low, 513 + ((t + k) % 2));
    end
  endtask

  task automatic test_smp_idle(input logic [15:0] sa, input logic [7:0] sv);
    int s, low, a0;
    bit to;
    sel = 1'b0;
    do_reset();
    mem[sa] = sv;
    for (int i = 0; i < int'($urandom_range(0, 1)); i++)
      bus_cycle(16'hFFF0, 8'h00, 1'b1);
    clear_logs();
    smp_got = 8'h00;
    a0 = ack_cnt;
    s = cyc;
    I_smp_addr = sa;
    I_smp_req = 1'b1;
    bus_cycle(16'hFFF0, 8'h00, 1'b1);
    run_idle(low, to);
    checks++;
    if (to || smp_got !== sv || o_sdata !== sv) begin
      errors++;
      $display("FAIL smp_idle_data got to=%0d %h/%h exp %h",
               to, smp_got, o_sdata, sv);
    end
    checks++;
    if (ack_cnt - a0 != 1) begin
      errors++;
      $display("FAIL smp_idle_ack got %0d clocks exp 1", ack_cnt - a0);
    end
    checks++;
    if (low != 2 + (s % 2)) begin
      errors++;
      $display("FAIL smp_idle_ready_low got %0d exp %0d", low, 2 + (s % 2));
    end
    checks++;
    if (rd_q.size() != 1 || rd_q[0] !== sa || odd_reads != 0
        || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL smp_idle_bus got n=%0d odd=%0d busy=%b exp 1 0 0",
               rd_q.size(), odd_reads, s_busy);
    end
  endtask

  task automatic test_smp_mid();
    logic [7:0] pg, sv;
    logic [15:0] sa;
    int t, low, bad, a0;
    bit to;
    sel = 1'b0;
    do_reset();
    pg = 8'($urandom_range(3, 8'h7F));
    for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'($urandom);
    sa = 16'hC000 | 16'($urandom_range(0, 255));
    sv = 8'h80 | 8'($urandom);
    mem[sa] = sv;
    I_smp_addr = sa;
    clear_logs();
    for (int i = 0; i <= 16; i++) exp_rd.push_back({pg, 8'(i)});
    exp_rd.push_back(sa);
    for (int i = 17; i < 256; i++) exp_rd.push_back({pg, 8'(i)});
    arm_addr = {pg, 8'h10};
    arm_en = 1'b1;
    a0 = ack_cnt;
    t = cyc;
    bus_cycle(16'h4014, pg, 1'b0);
    run_idle(low, to);
    arm_en = 1'b0;
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i] !== mem[{pg, 8'(i)}]) bad++;
    checks++;
    if (to || wr_q.size() != 256 || bad != 0) begin
      errors++;
      $display("FAIL smp_mid_writes got to=%0d n=%0d bad=%0d exp 0 256 0",
               to, wr_q.size(), bad);
    end
    bad = 0;
    foreach (rd_q[i])
      if (i >= exp_rd.size() || rd_q[i] !== exp_rd[i]) bad++;
    checks++;
    if (rd_q.size() != 257 || bad != 0 || odd_reads != 0) begin
      errors++;
      $display("FAIL smp_mid_reads got n=%0d bad=%0d odd=%0d exp 257 0 0",
               rd_q.size(), bad, odd_reads);
    end
    checks++;
    if (smp_got !== sv || ack_cnt - a0 != 1) begin
      errors++;
      $display("FAIL smp_mid_data got %h acks=%0d exp %h acks=1",
               smp_got, ack_cnt - a0, sv);
    end
    checks++;
    if (low != 515 + (t % 2)) begin
      errors++;
      $display("FAIL smp_mid_ready_low got %0d exp %0d", low, 515 + (t % 2));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pg;
    int low, bad;
    bit to;
    sel = 1'b0;
    pg = 8'($urandom_range(3, 8'h7F));
    for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'($urandom);
    clear_logs();
    bus_cycle(16'h4014, pg, 1'b0);
    for (int n = 0; n < 400; n++) begin
      bus_cycle(16'hFFF0, 8'h00, 1'b1);
      if (rd_q.size() == 129) break;
    end
    checks++;
    if (rd_q.size() != 129) begin
      errors++;
      $display("FAIL rst_mid_reach got %0d reads exp 129", rd_q.size());
    end
    I_reset = 1'b1;
    @(posedge I_clock); #1;
    I_reset = 1'b0;
    cyc = 0;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_sdata !== 8'h00
        || o_addr !== 16'hFFF0 || o_rdwr !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_state got rdy=%b bsy=%b sd=%h a=%h rw=%b exp 1 0 00 fff0 1",
               o_ready, o_busy, o_sdata, o_addr, o_rdwr);
    end
    clear_logs();
    bus_cycle(16'h4014, pg, 1'b0);
    run_idle(low, to);
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i] !== mem[{pg, 8'(i)}]) bad++;
    foreach (rd_q[i]) if (rd_q[i] !== {pg, 8'(i)}) bad++;
    checks++;
    if (to || wr_q.size() != 256 || rd_q.size() != 256 || bad != 0) begin
      errors++;
      $display("FAIL rst_mid_restart got to=%0d w=%0d r=%0d bad=%0d exp 0 256 256 0",
               to, wr_q.size(), rd_q.size(), bad);
    end
  endtask

  task automatic test_len4();
    int t, low, bad;
    bit to;
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) mem[16'h0300 + 16'(i)] = 8'($urandom);
    for (int i = 0; i < int'($urandom_range(0, 1)); i++)
      bus_cycle(16'hFFF0, 8'h00, 1'b1);
    clear_logs();
    t = cyc;
    bus_cycle(16'h4014, 8'h03, 1'b0);
    run_idle(low, to);
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i] !== mem[16'h0300 + 16'(i)]) bad++;
    foreach (rd_q[i]) if (rd_q[i] !== 16'h0300 + 16'(i)) bad++;
    checks++;
    if (to || wr_q.size() != 16 || rd_q.size() != 16 || bad != 0) begin
      errors++;
      $display("FAIL len4_copy got to=%0d w=%0d r=%0d bad=%0d exp 0 16 16 0",
               to, wr_q.size(), rd_q.size(), bad);
    end
    checks++;
    if (low != 33 + (t % 2) || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL len4_ready_low got %0d busy=%b exp %0d busy=0",
               low, s_busy, 33 + (t % 2));
    end
    sel = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    sel = 1'b0;
    arm_en = 1'b0;
    arm_addr = 16'h0000;
    smp_got = 8'h00;
    odd_reads = 0;
    I_reset = 1'b1;
    I_phy2 = 1'b0;
    I_cpu_addr = 16'hFFF0;
    I_cpu_wr_data = 8'h00;
    I_cpu_rdwr = 1'b1;
    I_smp_req = 1'b0;
    I_smp_addr = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_full_copy(0);
    test_full_copy(1);
    test_cpu_write();
    test_smp_idle(16'hC000, 8'h5A);
    test_smp_idle(16'hC000 | 16'($urandom_range(1, 255)),
                  8'h01 | 8'($urandom));
    test_smp_mid();
    test_reset_mid();
    test_len4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
